// File: rtl/opcode_sequencer_pkg.sv
// Shared definitions for the opcode sequencer.
// - CLS_CTRL  : instruction class (bits [15:14]) that marks a sequencer control word
// - ctrl_op_e : control-op codes in bits [13:12] of a control word
// - state_e   : sequencer FSM states
package opcode_sequencer_pkg;

  localparam logic [1:0] CLS_CTRL = 2'b10;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_END  = 2'b01,
    OP_LOOP = 2'b10,
    OP_RSV  = 2'b11
  } ctrl_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic is_ctrl(input logic [15:0] w);
    return w[15:14] == CLS_CTRL;
  endfunction

endpackage

// File: rtl/opcode_sequencer_program_memory.sv
// Program store for the opcode sequencer: synchronous write, combinational
// read, no reset (contents survive a sequencer reset).
// Ports:
//   clk    - write clock
//   we     - write strobe
//   waddr  - write address
//   wdata  - 16-bit word to write
//   raddr  - read address
//   rdata  - word at raddr (combinational)
module program_memory #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/opcode_sequencer.sv
// Opcode sequencer: steps through a small program memory and broadcasts each
// non-control word to the cores as opcode/execute. Control words (class 2'b10)
// implement NOP, END and a single-level LOOP; they never raise execute.
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   prog_we/addr/data       - program load port (honoured only while idle)
//   start                   - request to run the program from address 0
//   opcode, execute         - registered instruction broadcast
//   busy                    - high while running
//   done                    - one-cycle end-of-program pulse
//   pc                      - current program counter
module opcode_sequencer
  import opcode_sequencer_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_W     = $clog2(PROG_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  input  logic              start,
  output logic [15:0]       opcode,
  output logic              execute,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc
);

  state_e            state_q;
  logic              start_q;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       opcode_q;
  logic              execute_q;
  logic              done_q;
  logic [7:0]        loop_cnt_q;
  logic              loop_armed_q;

  logic [15:0]       instr;
  ctrl_op_e          cop;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] pc_inc;
  logic              at_last;

  program_memory #(.DEPTH(PROG_DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (prog_we && (state_q == ST_IDLE)),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (instr)
  );

  assign cop     = ctrl_op_e'(instr[13:12]);
  assign tgt     = instr[8 +: ADDR_W];
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign at_last = (pc_q == ADDR_W'(PROG_DEPTH - 1));

  // start is captured in a flop first, so the first issue lands two edges
  // after the edge that sampled start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      pc_q         <= '0;
      opcode_q     <= 16'h0000;
      execute_q    <= 1'b0;
      done_q       <= 1'b0;
      loop_cnt_q   <= 8'd0;
      loop_armed_q <= 1'b0;
    end else begin
      start_q <= start && (state_q == ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          execute_q <= 1'b0;
          done_q    <= 1'b0;
          if (start_q) begin
            pc_q         <= '0;
            loop_cnt_q   <= 8'd0;
            loop_armed_q <= 1'b0;
            state_q      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!is_ctrl(instr)) begin
            opcode_q  <= instr;
            execute_q <= 1'b1;
            // No wrap: issuing the last word ends the program.
            if (at_last) state_q <= ST_DONE;
            else         pc_q    <= pc_inc;
          end else begin
            execute_q <= 1'b0;
            case (cop)
              OP_END: state_q <= ST_DONE;
              OP_LOOP: begin
                if (!loop_armed_q && instr[7:0] != 8'd0) begin
                  loop_cnt_q   <= instr[7:0] - 8'd1;
                  loop_armed_q <= 1'b1;
                  pc_q         <= tgt;
                end else if (loop_armed_q && loop_cnt_q != 8'd0) begin
                  loop_cnt_q <= loop_cnt_q - 8'd1;
                  pc_q       <= tgt;
                end else begin
                  // Fall-through: N=0 unarmed, or final pass of an armed loop.
                  loop_armed_q <= 1'b0;
                  if (at_last) state_q <= ST_DONE;
                  else         pc_q    <= pc_inc;
                end
              end
              default: begin // NOP and reserved
                if (at_last) state_q <= ST_DONE;
                else         pc_q    <= pc_inc;
              end
            endcase
          end
        end
        ST_DONE: begin
          execute_q    <= 1'b0;
          done_q       <= 1'b1;
          loop_armed_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign opcode  = opcode_q;
  assign execute = execute_q;
  assign done    = done_q;
  assign pc      = pc_q;
  assign busy    = (state_q == ST_RUN);

endmodule

// File: tb/tb_opcode_sequencer.sv
module tb_opcode_sequencer;

  logic        clk;
  logic        rst_n;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic        start;
  logic [15:0] opcode;
  logic        execute;
  logic        busy;
  logic        done;
  logic [3:0]  pc;

  int n_checks = 0;
  int n_fail   = 0;

  opcode_sequencer #(.PROG_DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .opcode    (opcode),
    .execute   (execute),
    .busy      (busy),
    .done      (done),
    .pc        (pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check all outputs at once: {execute,busy,done}, opcode, pc.
  task automatic look(input string tag, input logic e, input logic b, input logic d,
                      input logic [15:0] op, input logic [3:0] p);
    chk({tag, ".ebd"}, {13'd0, execute, busy, done}, {13'd0, e, b, d});
    chk({tag, ".op"}, opcode, op);
    chk({tag, ".pc"}, {12'd0, pc}, {12'd0, p});
  endtask

  task automatic step(input string tag, input logic e, input logic b, input logic d,
                      input logic [15:0] op, input logic [3:0] p);
    tick();
    look(tag, e, b, d, op, p);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    #3;
    look("reset", 0, 0, 0, 16'h0000, 4'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Two issues then END
    wr(4'd0, 16'h0012); wr(4'd1, 16'h4202); wr(4'd2, 16'h9000);
    pulse_start();
    look("t1.sampled", 0, 0, 0, 16'h0000, 4'd0);
    step("t1.run0", 0, 1, 0, 16'h0000, 4'd0);
    step("t1.i0",   1, 1, 0, 16'h0012, 4'd1);
    step("t1.i1",   1, 1, 0, 16'h4202, 4'd2);
    step("t1.end",  0, 0, 0, 16'h4202, 4'd2);
    step("t1.done", 0, 0, 1, 16'h4202, 4'd2);
    step("t1.idle", 0, 0, 0, 16'h4202, 4'd2);

    // LOOP on itself, N=2 -> three evaluation cycles
    wr(4'd0, 16'h0001); wr(4'd1, 16'hA102); wr(4'd2, 16'h9000);
    pulse_start();
    step("t2.run0", 0, 1, 0, 16'h4202, 4'd0);
    step("t2.i0",   1, 1, 0, 16'h0001, 4'd1);
    step("t2.L1",   0, 1, 0, 16'h0001, 4'd1);
    step("t2.L2",   0, 1, 0, 16'h0001, 4'd1);
    step("t2.L3",   0, 1, 0, 16'h0001, 4'd2);
    step("t2.end",  0, 0, 0, 16'h0001, 4'd2);
    step("t2.done", 0, 0, 1, 16'h0001, 4'd2);

    // Loop body 0x4000 executed N+1 = 2 times
    wr(4'd0, 16'h0005); wr(4'd1, 16'h4000); wr(4'd2, 16'hA101); wr(4'd3, 16'h9000);
    pulse_start();
    step("t3.run0", 0, 1, 0, 16'h0001, 4'd0);
    step("t3.i0",   1, 1, 0, 16'h0005, 4'd1);
    step("t3.i1",   1, 1, 0, 16'h4000, 4'd2);
    step("t3.L1",   0, 1, 0, 16'h4000, 4'd1);
    step("t3.i1b",  1, 1, 0, 16'h4000, 4'd2);
    step("t3.L2",   0, 1, 0, 16'h4000, 4'd3);
    step("t3.end",  0, 0, 0, 16'h4000, 4'd3);
    step("t3.done", 0, 0, 1, 16'h4000, 4'd3);

    // Reserved op as NOP, LOOP with N=0 falls through
    wr(4'd0, 16'hB000); wr(4'd1, 16'hA300); wr(4'd2, 16'h0042); wr(4'd3, 16'h9000);
    pulse_start();
    step("t7.run0", 0, 1, 0, 16'h4000, 4'd0);
    step("t7.rsv",  0, 1, 0, 16'h4000, 4'd1);
    step("t7.L0",   0, 1, 0, 16'h4000, 4'd2);
    step("t7.i2",   1, 1, 0, 16'h0042, 4'd3);
    step("t7.end",  0, 0, 0, 16'h0042, 4'd3);
    step("t7.done", 0, 0, 1, 16'h0042, 4'd3);

    // Full memory of issues: 16 executes, ends at pc=15 without wrap
    for (int a = 0; a < 16; a++) wr(4'(a), 16'h4000);
    pulse_start();
    step("t4.run0", 0, 1, 0, 16'h0042, 4'd0);
    for (int k = 0; k < 15; k++) step($sformatf("t4.i%0d", k), 1, 1, 0, 16'h4000, 4'(k + 1));
    step("t4.i15",  1, 0, 0, 16'h4000, 4'd15);
    step("t4.done", 0, 0, 1, 16'h4000, 4'd15);
    step("t4.idle", 0, 0, 0, 16'h4000, 4'd15);

    // Writes and start during RUN are ignored
    wr(4'd0, 16'h0021); wr(4'd1, 16'h0022); wr(4'd2, 16'h9000);
    pulse_start();
    step("t5.run0", 0, 1, 0, 16'h4000, 4'd0);
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = 16'h1234; start = 1'b1;
    step("t5.i0",   1, 1, 0, 16'h0021, 4'd1);
    prog_we = 1'b0; start = 1'b0;
    step("t5.i1",   1, 1, 0, 16'h0022, 4'd2);
    step("t5.end",  0, 0, 0, 16'h0022, 4'd2);
    step("t5.done", 0, 0, 1, 16'h0022, 4'd2);
    step("t5.idle", 0, 0, 0, 16'h0022, 4'd2);
    pulse_start();
    step("t5.r.run0", 0, 1, 0, 16'h0022, 4'd0);
    step("t5.r.i0",   1, 1, 0, 16'h0021, 4'd1);
    step("t5.r.i1",   1, 1, 0, 16'h0022, 4'd2);
    step("t5.r.end",  0, 0, 0, 16'h0022, 4'd2);
    step("t5.r.done", 0, 0, 1, 16'h0022, 4'd2);

    // Reset mid-loop, then rerun with loop state cleared
    wr(4'd0, 16'h0001); wr(4'd1, 16'hA102); wr(4'd2, 16'h9000);
    pulse_start();
    step("t6.run0", 0, 1, 0, 16'h0022, 4'd0);
    step("t6.i0",   1, 1, 0, 16'h0001, 4'd1);
    step("t6.L1",   0, 1, 0, 16'h0001, 4'd1);
    rst_n = 1'b0;
    #2;
    look("t6.rst", 0, 0, 0, 16'h0000, 4'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    look("t6.rst.hold", 0, 0, 0, 16'h0000, 4'd0);
    pulse_start();
    step("t6.r.run0", 0, 1, 0, 16'h0000, 4'd0);
    step("t6.r.i0",   1, 1, 0, 16'h0001, 4'd1);
    step("t6.r.L1",   0, 1, 0, 16'h0001, 4'd1);
    step("t6.r.L2",   0, 1, 0, 16'h0001, 4'd1);
    step("t6.r.L3",   0, 1, 0, 16'h0001, 4'd2);
    step("t6.r.end",  0, 0, 0, 16'h0001, 4'd2);
    step("t6.r.done", 0, 0, 1, 16'h0001, 4'd2);
    step("t6.r.idle", 0, 0, 0, 16'h0001, 4'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
